// File: rtl/mem_pkg.sv
// mem_pkg: shared sizing defaults and helpers for the asymmetric RAM/FIFO family
package mem_pkg;

   localparam int DEF_WIDTHA     = 64;
   localparam int DEF_SIZEA      = 256;
   localparam int DEF_ADDRWIDTHA = 8;
   localparam int DEF_WIDTHB     = 16;
   localparam int DEF_SIZEB      = 1024;
   localparam int DEF_ADDRWIDTHB = 10;

   function automatic int log2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int ratio(input int wa, input int wb);
      return wa / wb;
   endfunction

endpackage

// File: rtl/ram_asym_sdp_write_wider.sv
// ram_asym_sdp_write_wider: simple dual-port RAM, wide write port, narrow registered read port
module ram_asym_sdp_write_wider
   import mem_pkg::*;
#(
   parameter int WIDTHA     = DEF_WIDTHA,
   parameter int ADDRWIDTHA = DEF_ADDRWIDTHA,
   parameter int WIDTHB     = DEF_WIDTHB,
   parameter int SIZEB      = DEF_SIZEB,
   parameter int ADDRWIDTHB = DEF_ADDRWIDTHB
)(
   input  logic                  clk,
   input  logic                  enaA,
   input  logic                  weA,
   input  logic [ADDRWIDTHA-1:0] addrA,
   input  logic [WIDTHA-1:0]     diA,
   input  logic                  enaB,
   input  logic [ADDRWIDTHB-1:0] addrB,
   output logic [WIDTHB-1:0]     doB
);

   localparam int RATIO = ratio(WIDTHA, WIDTHB);

   logic [WIDTHB-1:0] mem [SIZEB];

   // Each wide write lands as RATIO narrow words, lane 0 at the lowest narrow address
   always_ff @(posedge clk)
      if (enaA && weA)
         for (int i = 0; i < RATIO; i++)
            mem[ADDRWIDTHB'(addrA) * ADDRWIDTHB'(RATIO) + ADDRWIDTHB'(i)] <= diA[(i+1)*WIDTHB-1 -: WIDTHB];

   // Narrow read with one cycle of latency
   always_ff @(posedge clk)
      if (enaB) doB <= mem[addrB];

endmodule

// File: rtl/asym_fifo_write_wider.sv
// asym_fifo_write_wider: FWFT FIFO taking wide words and returning narrow words, lane 0 first
module asym_fifo_write_wider
   import mem_pkg::*;
#(
   parameter int WIDTHA     = DEF_WIDTHA,
   parameter int SIZEA      = DEF_SIZEA,
   parameter int ADDRWIDTHA = DEF_ADDRWIDTHA,
   parameter int WIDTHB     = DEF_WIDTHB,
   parameter int SIZEB      = DEF_SIZEB,
   parameter int ADDRWIDTHB = DEF_ADDRWIDTHB
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [WIDTHA-1:0]     wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [WIDTHB-1:0]     rd_data,
   input  logic                  flush,
   output logic [ADDRWIDTHB:0]   count
);

   localparam int RATIO = ratio(WIDTHA, WIDTHB);
   localparam logic [ADDRWIDTHB:0] SIZEBC = (ADDRWIDTHB+1)'(SIZEB);
   localparam logic [ADDRWIDTHB:0] RATIOC = (ADDRWIDTHB+1)'(RATIO);

   if (RATIO < 1 || (RATIO & (RATIO - 1)) != 0 || SIZEB != SIZEA * RATIO ||
       ADDRWIDTHB != ADDRWIDTHA + log2(RATIO)) begin : gBadCfg
      $error("asym_fifo_write_wider: inconsistent width/depth parameters");
   end

   logic [ADDRWIDTHA-1:0] wrPtr;
   logic [ADDRWIDTHB-1:0] rdPtr;
   logic [ADDRWIDTHB:0]   ramCount;
   logic [1:0]            outCount;
   logic [1:0]            occ;
   logic [WIDTHB-1:0]     head;
   logic [WIDTHB-1:0]     tail;
   logic [WIDTHB-1:0]     ramDo;
   logic                  readyEn;
   logic                  inflight;
   logic                  wrFire;
   logic                  pop;
   logic                  issue;

   assign wr_ready = readyEn && (SIZEBC - count >= RATIOC);
   assign wrFire   = wr_valid && wr_ready;
   assign rd_valid = outCount != 2'd0;
   assign pop      = rd_valid && rd_ready;
   assign rd_data  = head;
   assign occ      = outCount + {1'b0, inflight} - {1'b0, pop};
   assign issue    = ramCount != '0 && occ < 2'd2;

   ram_asym_sdp_write_wider #(
      .WIDTHA(WIDTHA), .ADDRWIDTHA(ADDRWIDTHA), .WIDTHB(WIDTHB),
      .SIZEB(SIZEB), .ADDRWIDTHB(ADDRWIDTHB)
   ) uRam (
      .clk(clk), .enaA(wrFire && !flush), .weA(1'b1), .addrA(wrPtr), .diA(wr_data),
      .enaB(issue), .addrB(rdPtr), .doB(ramDo)
   );

   // Pointers and occupancy; readyEn holds the write side off until the first edge after reset
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         readyEn  <= 1'b0;
         wrPtr    <= '0;
         rdPtr    <= '0;
         ramCount <= '0;
         count    <= '0;
         inflight <= 1'b0;
      end else if (flush) begin
         readyEn  <= 1'b1;
         wrPtr    <= '0;
         rdPtr    <= '0;
         ramCount <= '0;
         count    <= '0;
         inflight <= 1'b0;
      end else begin
         readyEn  <= 1'b1;
         if (wrFire) wrPtr <= wrPtr + 1'b1;
         if (issue) rdPtr <= rdPtr + 1'b1;
         ramCount <= ramCount + (wrFire ? RATIOC : '0) - (ADDRWIDTHB+1)'(issue);
         count    <= count + (wrFire ? RATIOC : '0) - (ADDRWIDTHB+1)'(pop);
         inflight <= issue;
      end

   // Two-entry output skid: head is the oldest word, RAM data arriving behind it fills the gap
   always_ff @(posedge clk or posedge rst)
      if (rst || flush) begin
         outCount <= 2'd0;
         head     <= '0;
         tail     <= '0;
      end else begin
         outCount <= outCount + {1'b0, inflight} - {1'b0, pop};
         if (pop && outCount == 2'd2) head <= tail;
         else if (inflight && (outCount == 2'd0 || pop)) head <= ramDo;
         if (inflight && outCount != 2'd0 && !(pop && outCount == 2'd1)) tail <= ramDo;
      end

endmodule

// File: tb/tb_asym_fifo_write_wider.sv
// tb_asym_fifo_write_wider: scenario tasks checked against a queue model of the FIFO
module tb_asym_fifo_write_wider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [63:0] wr_data = '0;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [15:0] rd_data;
   logic        flush = 1'b0;
   logic [10:0] count;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit bReady = 1'b0;
   logic [15:0] qd[$];
   int qa[$];

   asym_fifo_write_wider dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .flush(flush), .count(count)
   );

   always #5 clk = ~clk;

   // Edge counter used to time when each narrow word becomes visible
   always @(posedge clk) cyc <= cyc + 1;

   // A word written at edge N is visible after edge N+2; free space is counted in narrow words
   function automatic logic expReady();
      return bReady && (1024 - qd.size() >= 4);
   endfunction

   function automatic logic expValid();
      return qd.size() > 0 && qa[0] <= cyc;
   endfunction

   function automatic logic [15:0] expData();
      return expValid() ? qd[0] : 16'h0;
   endfunction

   // One clock of stimulus, with the model advanced by what the spec says must transfer
   task automatic drive(input logic wv, input logic [63:0] wd, input logic rr, input logic fl);
      logic er, ev;
      er = expReady();
      ev = expValid();
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      flush    = fl;
      @(posedge clk);
      #1;
      if (fl) begin
         qd.delete();
         qa.delete();
      end else begin
         if (rr && ev) begin
            void'(qd.pop_front());
            void'(qa.pop_front());
         end
         if (wv && er)
            for (int i = 0; i < 4; i++) begin
               qd.push_back(wd[i*16 +: 16]);
               qa.push_back(cyc + 2);
            end
      end
      bReady   = 1'b1;
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0 || count !== 11'd0) begin
         errors++;
         $display("FAIL reset_hold rdy=%b vld=%b dat=%h cnt=%0d required 0 0 0000 0", wr_ready, rd_valid, rd_data, count);
      end
      rst = 1'b0;
      bReady = 1'b0;
      #1;
      checks++;
      if (wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready got=%b required=0", wr_ready);
      end
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      checks++;
      if (wr_ready !== 1'b1 || count !== 11'd0) begin
         errors++;
         $display("FAIL reset_first_edge rdy=%b cnt=%0d required 1 0", wr_ready, count);
      end
   endtask

   task automatic test_single();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (wr_ready !== expReady() || rd_valid !== expValid() || count !== 11'(qd.size()) || (expValid() && rd_data !== qd[0])) begin
            errors++;
            $display("FAIL single k=%0d rdy=%b/%b vld=%b/%b cnt=%0d/%0d dat=%h/%h", k, wr_ready, expReady(), rd_valid, expValid(), count, qd.size(), rd_data, expData());
         end
         drive(k == 0, 64'h0004_0003_0002_0001, 1'b1, 1'b0);
      end
   endtask

   task automatic test_drain(input string name);
      for (int k = 0; k < 3000 && qd.size() > 0; k++) begin
         checks++;
         if (wr_ready !== expReady() || rd_valid !== expValid() || count !== 11'(qd.size()) || (expValid() && rd_data !== qd[0])) begin
            errors++;
            $display("FAIL drain_%s k=%0d rdy=%b/%b vld=%b/%b cnt=%0d/%0d dat=%h/%h", name, k, wr_ready, expReady(), rd_valid, expValid(), count, qd.size(), rd_data, expData());
         end
         drive(1'b0, 64'h0, 1'b1, 1'b0);
      end
      #1;
      checks++;
      if (qd.size() != 0 || count !== 11'd0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_%s_end model=%0d cnt=%0d vld=%b required 0 0 0", name, qd.size(), count, rd_valid);
      end
   endtask

   task automatic test_fill();
      logic [63:0] wd;
      for (int i = 0; i < 257; i++) begin
         checks++;
         if (wr_ready !== expReady() || rd_valid !== expValid() || count !== 11'(qd.size()) || (expValid() && rd_data !== qd[0])) begin
            errors++;
            $display("FAIL fill i=%0d rdy=%b/%b vld=%b/%b cnt=%0d/%0d dat=%h/%h", i, wr_ready, expReady(), rd_valid, expValid(), count, qd.size(), rd_data, expData());
         end
         wd = {16'(i*4+3), 16'(i*4+2), 16'(i*4+1), 16'(i*4)};
         drive(1'b1, wd, 1'b0, 1'b0);
      end
      checks++;
      if (count !== 11'd1024 || wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_full cnt=%0d rdy=%b required 1024 0", count, wr_ready);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
         checks++;
         if (wr_ready !== (k == 3) || count !== 11'(1023 - k) || rd_data !== qd[0]) begin
            errors++;
            $display("FAIL fill_pop k=%0d rdy=%b cnt=%0d dat=%h required %b %0d %h", k, wr_ready, count, rd_data, k == 3, 1023 - k, qd[0]);
         end
      end
   endtask

   task automatic test_stream();
      int acc = 0;
      int k = 0;
      while (acc < 600 && k < 5000) begin
         checks++;
         if (wr_ready !== expReady() || rd_valid !== expValid() || count !== 11'(qd.size()) || (expValid() && rd_data !== qd[0])) begin
            errors++;
            $display("FAIL stream k=%0d rdy=%b/%b vld=%b/%b cnt=%0d/%0d dat=%h/%h", k, wr_ready, expReady(), rd_valid, expValid(), count, qd.size(), rd_data, expData());
         end
         if (expReady()) acc++;
         drive(1'b1, {16'(acc*4+3), 16'(acc*4+2), 16'(acc*4+1), 16'(acc*4)}, 1'b1, 1'b0);
         k++;
      end
      checks++;
      if (acc != 600) begin
         errors++;
         $display("FAIL stream_timeout accepted=%0d required=600", acc);
      end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 1500; k++) begin
         checks++;
         if (wr_ready !== expReady() || rd_valid !== expValid() || count !== 11'(qd.size()) || (expValid() && rd_data !== qd[0])) begin
            errors++;
            $display("FAIL backpressure k=%0d rdy=%b/%b vld=%b/%b cnt=%0d/%0d dat=%h/%h", k, wr_ready, expReady(), rd_valid, expValid(), count, qd.size(), rd_data, expData());
         end
         drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 10; k++) drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      for (int k = 0; k < 20 && qd.size() > 37; k++) drive(1'b0, 64'h0, 1'b1, 1'b0);
      checks++;
      if (count !== 11'd37 || count !== 11'(qd.size())) begin
         errors++;
         $display("FAIL flush_setup cnt=%0d required 37", count);
      end
      drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b1);
      checks++;
      if (count !== 11'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_clear cnt=%0d vld=%b rdy=%b required 0 0 1", count, rd_valid, wr_ready);
      end
      drive(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b0);
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'hDDDD || count !== 11'd4) begin
         errors++;
         $display("FAIL flush_refill vld=%b dat=%h cnt=%0d required 1 dddd 4", rd_valid, rd_data, count);
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 20; k++) drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0 || count !== 11'd0) begin
         errors++;
         $display("FAIL async_reset rdy=%b vld=%b dat=%h cnt=%0d required 0 0 0000 0", wr_ready, rd_valid, rd_data, count);
      end
      qd.delete();
      qa.delete();
      bReady = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         checks++;
         if (wr_ready !== expReady() || rd_valid !== expValid() || count !== 11'(qd.size()) || (expValid() && rd_data !== qd[0])) begin
            errors++;
            $display("FAIL after_reset k=%0d rdy=%b/%b vld=%b/%b cnt=%0d/%0d dat=%h/%h", k, wr_ready, expReady(), rd_valid, expValid(), count, qd.size(), rd_data, expData());
         end
         drive(k > 2 && k < 8, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_drain("single");
      test_fill();
      test_drain("fill");
      test_stream();
      test_drain("stream");
      test_backpressure();
      test_drain("backpressure");
      test_flush();
      test_drain("flush");
      test_async_reset();
      test_drain("async_reset");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
